regfile_rd_seq: RTL and testbench

- Sequencing front-end for the single-read-port, single-write-port 32x32 distributed-RAM register file. Sits between the CPU decode/writeback logic and the RAM.
- Clears the RAM after reset.
- Time-multiplexes the one asynchronous read port to fetch rs1 then rs2, and returns both operands under a valid/ready handshake.
- Applies x0 semantics, write-to-read forwarding, and suppression of writes to x0.

---
 rtl/regfile_pkg.sv | 15 +
 rtl/regfile_rd_fwd.sv | 32 +++
 rtl/regfile_rd_seq.sv | 185 ++++++++++++++++++
 tb/tb_regfile_rd_seq.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared types and constants for the register-file read sequencer.
//   state_e  : sequencer states (zero-fill sweep, idle, second read, response)
//   REG_ZERO : architectural zero register index
package regfile_pkg;

  typedef enum logic [1:0] {
    CLEAR = 2'd0,
    IDLE  = 2'd1,
    RD2   = 2'd2,
    RSP   = 2'd3
  } state_e;

  localparam int unsigned REG_ZERO = 0;

endpackage

// File: rtl/regfile_rd_fwd.sv
// Operand value selection for one register index.
//   rd_idx  : register index being captured
//   rd_data : value to use when nothing overrides it (RAM read or held value)
//   wr_fire : a writeback is accepted this cycle
//   wr_rd   : writeback destination index
//   wr_data : writeback value
//   val_c   : resulting operand value (x0 -> 0, else forwarded write, else rd_data)
module regfile_rd_fwd
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 5
) (
  input  logic [ADDR_WIDTH-1:0] rd_idx,
  input  logic [DATA_WIDTH-1:0] rd_data,
  input  logic                  wr_fire,
  input  logic [ADDR_WIDTH-1:0] wr_rd,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic [DATA_WIDTH-1:0] val_c
);

  // x0 wins over everything; a same-cycle write wins over the stale source
  always_comb begin
    val_c = rd_data;
    if (rd_idx == ADDR_WIDTH'(REG_ZERO)) begin
      val_c = '0;
    end else if (wr_fire && (wr_rd == rd_idx)) begin
      val_c = wr_data;
    end
  end

endmodule

// File: rtl/regfile_rd_seq.sv
// Sequencing front-end for a 1R/1W distributed-RAM register file.
// Zero-fills the RAM after reset, then time-multiplexes the single async read
// port to fetch rs1 and rs2, returning both under a valid/ready handshake.
// Held operands track later writes so a response always shows current
// register contents.
//   clk, rst                  : clock, synchronous active-high reset
//   req_valid/req_ready       : operand request handshake, req_rs1/req_rs2 indices
//   wr_valid/wr_ready         : writeback handshake, wr_rd index, wr_data value
//   rsp_valid/rsp_ready       : operand response handshake, rsp_rs1_val/rsp_rs2_val
//   ram_raddr/ram_do          : RAM asynchronous read port
//   ram_we/ram_waddr/ram_di   : RAM synchronous write port (clocked by clk)
module regfile_rd_seq
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned ADDR_WIDTH     = 5,
  parameter bit          CLEAR_ON_RESET = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_WIDTH-1:0] req_rs1,
  input  logic [ADDR_WIDTH-1:0] req_rs2,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [ADDR_WIDTH-1:0] wr_rd,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rs1_val,
  output logic [DATA_WIDTH-1:0] rsp_rs2_val,
  output logic [ADDR_WIDTH-1:0] ram_raddr,
  input  logic [DATA_WIDTH-1:0] ram_do,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_waddr,
  output logic [DATA_WIDTH-1:0] ram_di
);

  localparam int unsigned DEPTH     = 2 ** ADDR_WIDTH;
  localparam state_e      RST_STATE = CLEAR_ON_RESET ? CLEAR : IDLE;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] idx_q, idx_d;
  logic [ADDR_WIDTH-1:0] rs1_q, rs1_d;
  logic [ADDR_WIDTH-1:0] rs2_q, rs2_d;
  logic [DATA_WIDTH-1:0] rs1_val_q, rs1_val_d;
  logic [DATA_WIDTH-1:0] rs2_val_q, rs2_val_d;
  logic                  rsp_valid_q, rsp_valid_d;

  logic                  wr_fire;
  logic [DATA_WIDTH-1:0] port_src;
  logic [DATA_WIDTH-1:0] port_val_c;
  logic [DATA_WIDTH-1:0] hold1_val_c;

  // Write acceptance and read address depend on state only, so they are kept
  // out of the next-state block that consumes the forwarded values.
  assign wr_ready  = (state_q != CLEAR);
  assign wr_fire   = wr_valid && wr_ready && !rst;
  assign ram_raddr = (state_q == IDLE) ? req_rs1 : rs2_q;

  // In RSP the read port is idle, so its selector refreshes the held rs2 value
  assign port_src  = (state_q == RSP) ? rs2_val_q : ram_do;

  // Read-port path: rs1 capture in IDLE, rs2 capture in RD2, rs2 update in RSP
  regfile_rd_fwd #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_fwd_port (
    .rd_idx  (ram_raddr),
    .rd_data (port_src),
    .wr_fire (wr_fire),
    .wr_rd   (wr_rd),
    .wr_data (wr_data),
    .val_c   (port_val_c)
  );

  // Live update of the held rs1 value while the request is in flight
  regfile_rd_fwd #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_fwd_hold (
    .rd_idx  (rs1_q),
    .rd_data (rs1_val_q),
    .wr_fire (wr_fire),
    .wr_rd   (wr_rd),
    .wr_data (wr_data),
    .val_c   (hold1_val_c)
  );

  // State and operand registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= RST_STATE;
      idx_q       <= '0;
      rs1_q       <= '0;
      rs2_q       <= '0;
      rs1_val_q   <= '0;
      rs2_val_q   <= '0;
      rsp_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      rs1_q       <= rs1_d;
      rs2_q       <= rs2_d;
      rs1_val_q   <= rs1_val_d;
      rs2_val_q   <= rs2_val_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end

  // Next-state and request-side outputs
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    rs1_d       = rs1_q;
    rs2_d       = rs2_q;
    rs1_val_d   = rs1_val_q;
    rs2_val_d   = rs2_val_q;
    rsp_valid_d = rsp_valid_q;
    req_ready   = 1'b0;

    unique case (state_q)
      CLEAR: begin
        idx_d = idx_q + ADDR_WIDTH'(1);
        if (idx_q == ADDR_WIDTH'(DEPTH - 1)) begin
          idx_d   = '0;
          state_d = IDLE;
        end
      end

      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          rs1_d     = req_rs1;
          rs2_d     = req_rs2;
          rs1_val_d = port_val_c;
          state_d   = RD2;
        end
      end

      RD2: begin
        rs1_val_d   = hold1_val_c;
        rs2_val_d   = port_val_c;
        rsp_valid_d = 1'b1;
        state_d     = RSP;
      end

      RSP: begin
        rs1_val_d = hold1_val_c;
        rs2_val_d = port_val_c;
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end

      default: begin
        state_d = RST_STATE;
      end
    endcase
  end

  // RAM write port: zero-fill sweep, else accepted writebacks that are not x0
  always_comb begin
    ram_we    = 1'b0;
    ram_waddr = wr_rd;
    ram_di    = wr_data;
    if (state_q == CLEAR) begin
      ram_we    = 1'b1;
      ram_waddr = idx_q;
      ram_di    = '0;
    end else if (wr_fire && (wr_rd != ADDR_WIDTH'(REG_ZERO))) begin
      ram_we = 1'b1;
    end
    if (rst) begin
      ram_we = 1'b0;
    end
  end

  assign rsp_valid   = rsp_valid_q;
  assign rsp_rs1_val = rs1_val_q;
  assign rsp_rs2_val = rs2_val_q;

endmodule

// File: tb/tb_regfile_rd_seq.sv
// Bench for regfile_rd_seq: directed scenarios with literal expectations plus
// an architectural model (register array + pending request queue) checked
// every cycle on the falling edge.
module tb_regfile_rd_seq;

  localparam int unsigned DW    = 32;
  localparam int unsigned AW    = 5;
  localparam int unsigned DEPTH = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid;
  logic          req_ready;
  logic [AW-1:0] req_rs1;
  logic [AW-1:0] req_rs2;
  logic          wr_valid;
  logic          wr_ready;
  logic [AW-1:0] wr_rd;
  logic [DW-1:0] wr_data;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_rs1_val;
  logic [DW-1:0] rsp_rs2_val;
  logic [AW-1:0] ram_raddr;
  logic [DW-1:0] ram_do;
  logic          ram_we;
  logic [AW-1:0] ram_waddr;
  logic [DW-1:0] ram_di;

  regfile_rd_seq #(
    .DATA_WIDTH     (DW),
    .ADDR_WIDTH     (AW),
    .CLEAR_ON_RESET (1'b1)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_rs1     (req_rs1),
    .req_rs2     (req_rs2),
    .wr_valid    (wr_valid),
    .wr_ready    (wr_ready),
    .wr_rd       (wr_rd),
    .wr_data     (wr_data),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_rs1_val (rsp_rs1_val),
    .rsp_rs2_val (rsp_rs2_val),
    .ram_raddr   (ram_raddr),
    .ram_do      (ram_do),
    .ram_we      (ram_we),
    .ram_waddr   (ram_waddr),
    .ram_di      (ram_di)
  );

  always #5 clk = ~clk;

  // Distributed RAM: async read, sync write; pre-filled with junk so the
  // zero-fill sweep is observable.
  logic [DW-1:0] mem [DEPTH];
  logic          fill;
  assign ram_do = mem[ram_raddr];
  always @(posedge clk) begin
    if (fill) begin
      for (int i = 0; i < int'(DEPTH); i++) mem[i] <= 32'hBAD0_0000 | 32'(i);
    end else if (ram_we) begin
      mem[ram_waddr] <= ram_di;
    end
  end

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int dut_rsp_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Architectural model
  typedef struct {
    logic [AW-1:0] rs1;
    logic [AW-1:0] rs2;
    int            n;     // posedge count at which the request is accepted
  } req_t;

  logic [DW-1:0] arch [DEPTH];
  req_t          pend [$];
  int unsigned   clear_left = 0;
  bit            live = 1'b0;

  always @(negedge clk) begin
    bit   exp_rdy, exp_wrdy, exp_val, exp_we;
    req_t r;
    if (rst) begin
      check("ram_we_in_reset", 32'(ram_we), 32'd0);
      live       = 1'b1;
      pend.delete();
      clear_left = DEPTH;
      for (int i = 0; i < int'(DEPTH); i++) arch[i] = '0;
    end else if (live) begin
      exp_rdy  = (clear_left == 0) && (pend.size() == 0);
      exp_wrdy = (clear_left == 0);
      exp_val  = (pend.size() > 0) && (cyc >= pend[0].n + 1);
      check("req_ready", 32'(req_ready), 32'(exp_rdy));
      check("wr_ready", 32'(wr_ready), 32'(exp_wrdy));
      check("rsp_valid", 32'(rsp_valid), 32'(exp_val));
      if (exp_val) begin
        check("model_rs1_val", rsp_rs1_val, arch[pend[0].rs1]);
        check("model_rs2_val", rsp_rs2_val, arch[pend[0].rs2]);
      end
      if (clear_left > 0) begin
        check("sweep_we", 32'(ram_we), 32'd1);
        check("sweep_waddr", 32'(ram_waddr), 32'(DEPTH - clear_left));
        check("sweep_di", ram_di, 32'd0);
      end else begin
        exp_we = wr_valid && (wr_rd != '0);
        check("ram_we", 32'(ram_we), 32'(exp_we));
        if (exp_we) begin
          check("ram_waddr", 32'(ram_waddr), 32'(wr_rd));
          check("ram_di", ram_di, wr_data);
        end
      end
      // Events that take effect at the coming rising edge
      if (rsp_valid && rsp_ready) dut_rsp_cnt++;
      if (exp_val && rsp_ready) void'(pend.pop_front());
      if (exp_rdy && req_valid) begin
        r.rs1 = req_rs1;
        r.rs2 = req_rs2;
        r.n   = cyc + 1;
        pend.push_back(r);
      end
      if (exp_wrdy && wr_valid && (wr_rd != '0)) arch[wr_rd] = wr_data;
      if (clear_left > 0) clear_left--;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [AW-1:0] rd, input logic [DW-1:0] d);
    wr_valid = 1'b1;
    wr_rd    = rd;
    wr_data  = d;
    step();
    wr_valid = 1'b0;
  endtask

  // Issue a request, check latency and literal operand values; optionally
  // also issue a write in the accept cycle and release the response.
  task automatic do_read(input logic [AW-1:0] a, input logic [AW-1:0] b,
                         input logic [DW-1:0] e1, input logic [DW-1:0] e2,
                         input bit with_wr, input logic [AW-1:0] wrd,
                         input logic [DW-1:0] wd, input bit release_rsp);
    bit ok;
    int n;
    req_valid = 1'b1;
    req_rs1   = a;
    req_rs2   = b;
    if (with_wr) begin
      wr_valid = 1'b1;
      wr_rd    = wrd;
      wr_data  = wd;
    end
    ok = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      if (req_ready) ok = 1'b1;
    end
    check("req_accept_timeout", 32'(ok), 32'd1);
    step();
    req_valid = 1'b0;
    wr_valid  = 1'b0;
    ok = 1'b0;
    n  = 0;
    for (int i = 1; i <= 10 && !ok; i++) begin
      @(negedge clk);
      if (rsp_valid) begin
        ok = 1'b1;
        n  = i;
      end
    end
    check("rsp_latency", 32'(n), 32'd2);
    check("lit_rs1_val", rsp_rs1_val, e1);
    check("lit_rs2_val", rsp_rs2_val, e2);
    if (release_rsp) begin
      step();
      rsp_ready = 1'b1;
      step();
      rsp_ready = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int we_cnt;
    int first_ready;
    int acc [4];
    int k;
    int base_cnt;
    bit ok;
    logic [AW-1:0] p1 [4];
    logic [AW-1:0] p2 [4];

    rst = 1'b1; fill = 1'b1;
    req_valid = 1'b0; req_rs1 = '0; req_rs2 = '0;
    wr_valid = 1'b0; wr_rd = '0; wr_data = '0; rsp_ready = 1'b0;
    step();
    fill = 1'b0;
    @(negedge clk);
    check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    check("reset_rsp_rs1", rsp_rs1_val, 32'd0);
    check("reset_rsp_rs2", rsp_rs2_val, 32'd0);
    check("reset_req_ready", 32'(req_ready), 32'd0);
    check("reset_wr_ready", 32'(wr_ready), 32'd0);
    step();
    step();
    rst = 1'b0;

    // Zero-fill sweep: 32 write cycles, then req_ready
    we_cnt = 0;
    first_ready = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (ram_we) we_cnt++;
      if (req_ready && first_ready < 0) first_ready = i;
    end
    check("sweep_we_count", 32'(we_cnt), 32'd32);
    check("first_req_ready", 32'(first_ready), 32'd32);
    step();
    do_read(5'd5, 5'd7, 32'd0, 32'd0, 1'b0, '0, '0, 1'b1);

    // Plain write then read with x0 as rs2
    do_write(5'd5, 32'hDEAD_BEEF);
    step();
    do_read(5'd5, 5'd0, 32'hDEAD_BEEF, 32'd0, 1'b0, '0, '0, 1'b1);

    // Write accepted in the same cycle as the request: forwarded
    do_read(5'd3, 5'd3, 32'h1234_5678, 32'h1234_5678, 1'b1, 5'd3, 32'h1234_5678, 1'b1);

    // Held response tracks a later write; a write to x0 changes nothing
    do_read(5'd3, 5'd3, 32'h1234_5678, 32'h1234_5678, 1'b0, '0, '0, 1'b0);
    step();
    do_write(5'd3, 32'hA5A5_A5A5);
    @(negedge clk);
    check("held_valid", 32'(rsp_valid), 32'd1);
    check("live_rs1", rsp_rs1_val, 32'hA5A5_A5A5);
    check("live_rs2", rsp_rs2_val, 32'hA5A5_A5A5);
    step();
    wr_valid = 1'b1; wr_rd = 5'd0; wr_data = 32'hFFFF_FFFF;
    @(negedge clk);
    check("x0_ram_we", 32'(ram_we), 32'd0);
    check("x0_wr_ready", 32'(wr_ready), 32'd1);
    step();
    wr_valid = 1'b0;
    @(negedge clk);
    check("x0_rs1_unchanged", rsp_rs1_val, 32'hA5A5_A5A5);
    check("x0_rs2_unchanged", rsp_rs2_val, 32'hA5A5_A5A5);
    step();
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;

    // Reset while the request sits in RD2
    req_valid = 1'b1; req_rs1 = 5'd5; req_rs2 = 5'd5;
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (req_ready) ok = 1'b1;
    end
    check("rd2_accept_timeout", 32'(ok), 32'd1);
    step();
    req_valid = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    check("rst_rd2_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rd2_req_ready", 32'(req_ready), 32'd0);
    check("rst_sweep_restart_we", 32'(ram_we), 32'd1);
    check("rst_sweep_restart_addr", 32'(ram_waddr), 32'd0);
    step();
    do_read(5'd5, 5'd5, 32'd0, 32'd0, 1'b0, '0, '0, 1'b1);

    // Back-to-back requests with rsp_ready tied high
    do_write(5'd1, 32'h1111_1111);
    do_write(5'd2, 32'h2222_2222);
    do_write(5'd3, 32'h3333_3333);
    do_write(5'd4, 32'h4444_4444);
    p1[0] = 5'd1; p2[0] = 5'd2;
    p1[1] = 5'd3; p2[1] = 5'd4;
    p1[2] = 5'd2; p2[2] = 5'd1;
    p1[3] = 5'd4; p2[3] = 5'd0;
    base_cnt  = dut_rsp_cnt;
    rsp_ready = 1'b1;
    req_valid = 1'b1; req_rs1 = p1[0]; req_rs2 = p2[0];
    k = 0;
    for (int t = 0; t < 60 && k < 4; t++) begin
      @(negedge clk);
      if (req_ready) begin
        acc[k] = cyc;
        k++;
        step();
        if (k < 4) begin
          req_rs1 = p1[k];
          req_rs2 = p2[k];
        end else begin
          req_valid = 1'b0;
        end
      end
    end
    check("b2b_accepts", 32'(k), 32'd4);
    for (int i = 1; i < 4; i++) check("b2b_spacing", 32'(acc[i] - acc[i-1]), 32'd3);
    for (int i = 0; i < 6; i++) step();
    @(negedge clk);
    check("b2b_rsp_count", 32'(dut_rsp_cnt - base_cnt), 32'd4);
    check("b2b_drained", 32'(rsp_valid), 32'd0);
    rsp_ready = 1'b0;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
